pulse_gen_multi: RTL and testbench

Parametrised multi-channel successor to the single fixed-period pulse detector/generator. It produces up to NCH independent pulse trains, each with a programmable period, pulse width and periodic/one-shot mode. Configuration is double-buffered so that new settings never truncate a running period. It sits beside the control logic as the common source of sample strobes and timeout pulses. With NCH=1, DEF_PERIOD=10, DEF_WIDTH=1 and AUTO_START=1 it reproduces the legacy behaviour: a 1-cycle pulse every 11 clocks from reset.

---
 rtl/pulse_gen_multi.sv | 137 +++++++++++++
 tb/tb_pulse_gen_multi.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: NCH independent pulse-train generators with programmable
// period, width and periodic/one-shot mode. Configuration is double-buffered:
// cfg writes land in a shadow set, which is copied to the active set on start
// and at every period boundary, so a new setting never truncates a period.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   en           global count enable; low freezes cnt, wcnt and pulse
//   start, stop  per-channel strobes (act regardless of en; stop wins)
//   cfg_*        shadow config write: channel, period P, width W, one-shot
//   pulse        registered pulse outputs
//   busy         channel running, or a one-shot pulse still high
module pulse_gen_multi #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_PERIOD = 10,
  parameter int unsigned DEF_WIDTH  = 1,
  parameter bit          AUTO_START = 1'b0,
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic             cfg_oneshot,
  output logic [NCH-1:0]   pulse,
  output logic [NCH-1:0]   busy
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [CNT_W-1:0] DefP = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DefW = CNT_W'(DEF_WIDTH);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] sh_p_q, sh_p_d, sh_w_q, sh_w_d;
    logic [CNT_W-1:0] act_p_q, act_p_d, act_w_q, act_w_d;
    logic             sh_os_q, sh_os_d, act_os_q, act_os_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
    logic             pulse_q, pulse_d;
    logic             cfg_hit, terminal;

    // Out-of-range channel numbers never match any i, so they are dropped.
    assign cfg_hit  = cfg_we && (32'(cfg_ch) == i);
    assign terminal = (state_q == StRun) && en && (cnt_q == act_p_q);

    always_comb begin
      state_d  = state_q;
      sh_p_d   = sh_p_q;
      sh_w_d   = sh_w_q;
      sh_os_d  = sh_os_q;
      act_p_d  = act_p_q;
      act_w_d  = act_w_q;
      act_os_d = act_os_q;
      cnt_d    = cnt_q;
      wcnt_d   = wcnt_q;
      pulse_d  = pulse_q;

      if (cfg_hit) begin
        sh_p_d  = cfg_period;
        sh_w_d  = cfg_width;
        sh_os_d = cfg_oneshot;
      end

      if (stop[i]) begin
        state_d = StIdle;
        cnt_d   = '0;
        wcnt_d  = '0;
        pulse_d = 1'b0;
      end else begin
        if (en) begin
          if (terminal) begin
            // Width of the period just ended; W=0 behaves as W=1.
            pulse_d  = 1'b1;
            wcnt_d   = (act_w_q == '0) ? '0 : act_w_q - CNT_W'(1);
            cnt_d    = '0;
            act_p_d  = sh_p_q;
            act_w_d  = sh_w_q;
            act_os_d = sh_os_q;
            if (act_os_q) state_d = StIdle;
          end else begin
            if (wcnt_q != '0) begin
              wcnt_d = wcnt_q - CNT_W'(1);
            end else begin
              pulse_d = 1'b0;
            end
            if (state_q == StRun) cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Start/retrigger restarts the period; pulse and wcnt are left alone.
        if (start[i]) begin
          state_d  = StRun;
          cnt_d    = '0;
          act_p_d  = sh_p_q;
          act_w_d  = sh_w_q;
          act_os_d = sh_os_q;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= AUTO_START ? StRun : StIdle;
        sh_p_q   <= DefP;
        sh_w_q   <= DefW;
        sh_os_q  <= 1'b0;
        act_p_q  <= DefP;
        act_w_q  <= DefW;
        act_os_q <= 1'b0;
        cnt_q    <= '0;
        wcnt_q   <= '0;
        pulse_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        sh_p_q   <= sh_p_d;
        sh_w_q   <= sh_w_d;
        sh_os_q  <= sh_os_d;
        act_p_q  <= act_p_d;
        act_w_q  <= act_w_d;
        act_os_q <= act_os_d;
        cnt_q    <= cnt_d;
        wcnt_q   <= wcnt_d;
        pulse_q  <= pulse_d;
      end
    end

    assign pulse[i] = pulse_q;
    assign busy[i]  = (state_q == StRun) | (pulse_q & act_os_q);
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
module tb_pulse_gen_multi;

  localparam int NB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Legacy instance: NCH=1, defaults, AUTO_START=1.
  logic       pulse_a, busy_a;
  // Main instance: NCH=3 so that cfg_ch=3 is an out-of-range channel.
  logic          en = 1'b1;
  logic [NB-1:0] start_b = '0, stop_b = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [15:0]   cfg_period = '0, cfg_width = '0;
  logic          cfg_oneshot = 1'b0;
  logic [NB-1:0] pulse_b, busy_b;

  pulse_gen_multi #(.NCH(1), .CNT_W(16), .DEF_PERIOD(10), .DEF_WIDTH(1), .AUTO_START(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(1'b1), .start(1'b0), .stop(1'b0), .cfg_we(1'b0),
    .cfg_ch(1'b0), .cfg_period(16'd0), .cfg_width(16'd0), .cfg_oneshot(1'b0),
    .pulse(pulse_a), .busy(busy_a)
  );

  pulse_gen_multi #(.NCH(NB), .CNT_W(16), .DEF_PERIOD(10), .DEF_WIDTH(1), .AUTO_START(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .start(start_b), .stop(stop_b), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_oneshot(cfg_oneshot),
    .pulse(pulse_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Schedule model: time advances only on enabled edges; each channel knows
  // the enabled-time of its next period boundary and of its last pulse start.
  longint      t;
  longint      next_term [NB];
  longint      last_term [NB];
  bit          has_term  [NB];
  int unsigned weff      [NB];
  bit          running   [NB];
  int unsigned sh_p [NB], sh_w [NB], act_p [NB], act_w [NB];
  bit          sh_os [NB], act_os [NB];

  task automatic model_reset();
    t = 0;
    for (int c = 0; c < NB; c++) begin
      sh_p[c] = 10; sh_w[c] = 1; sh_os[c] = 0;
      act_p[c] = 10; act_w[c] = 1; act_os[c] = 0;
      running[c] = 0; next_term[c] = 11; has_term[c] = 0; last_term[c] = 0; weff[c] = 1;
    end
  endtask

  task automatic model_edge();
    longint tn;
    tn = t + (en ? 1 : 0);
    for (int c = 0; c < NB; c++) begin
      if (stop_b[c]) begin
        running[c]  = 0;
        has_term[c] = 0;
      end else begin
        if (en && running[c] && tn == next_term[c]) begin
          has_term[c]  = 1;
          last_term[c] = tn;
          weff[c]      = (act_w[c] == 0) ? 1 : act_w[c];
          if (act_os[c]) running[c] = 0;
          act_p[c] = sh_p[c]; act_w[c] = sh_w[c]; act_os[c] = sh_os[c];
          next_term[c] = tn + act_p[c] + 1;
        end
        if (start_b[c]) begin
          running[c] = 1;
          act_p[c] = sh_p[c]; act_w[c] = sh_w[c]; act_os[c] = sh_os[c];
          next_term[c] = tn + act_p[c] + 1;
        end
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        sh_p[c] = cfg_period; sh_w[c] = cfg_width; sh_os[c] = cfg_oneshot;
      end
    end
    t = tn;
  endtask

  function automatic logic [NB-1:0] exp_pulse();
    logic [NB-1:0] v;
    v = '0;
    for (int c = 0; c < NB; c++)
      v[c] = has_term[c] && ((t - last_term[c]) < longint'(weff[c]));
    return v;
  endfunction

  function automatic logic [NB-1:0] exp_busy();
    logic [NB-1:0] v, p;
    p = exp_pulse();
    v = '0;
    for (int c = 0; c < NB; c++) v[c] = running[c] | (p[c] & act_os[c]);
    return v;
  endfunction

  int n_a;  // edges since reset release, for the legacy instance

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      n_a = 0;
    end else begin
      model_edge();
      n_a++;
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("model_pulse", 32'(pulse_b), 32'(exp_pulse()));
      check("model_busy", 32'(busy_b), 32'(exp_busy()));
      check("legacy_pulse", 32'(pulse_a), 32'((n_a != 0) && (n_a % 11 == 0)));
      check("legacy_busy", 32'(busy_a), 32'd1);
    end
  end

  task automatic do_cfg(input int ch, input int p, input int w, input bit os);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 16'(p); cfg_width = 16'(w); cfg_oneshot = os;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [NB-1:0] m);
    start_b = m;
    @(negedge clk);
    start_b = '0;
  endtask

  task automatic do_stop(input logic [NB-1:0] m);
    stop_b = m;
    @(negedge clk);
    stop_b = '0;
  endtask

  bit found;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_pulse_b", 32'(pulse_b), 32'd0);
    check("reset_busy_b", 32'(busy_b), 32'd0);
    check("reset_pulse_a", 32'(pulse_a), 32'd0);
    chk_on = 1'b1;

    // ch2: P=3, W=2 periodic; first rise 4 edges after start.
    do_cfg(2, 3, 2, 1'b0);
    do_start(3'b100);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 3) check("ch2_before_rise", 32'(pulse_b[2]), 32'd0);
      if (j == 4) check("ch2_rise", 32'(pulse_b[2]), 32'd1);
      if (j == 5) check("ch2_width2", 32'(pulse_b[2]), 32'd1);
      if (j == 6) check("ch2_fall", 32'(pulse_b[2]), 32'd0);
      if (j == 8) check("ch2_repeat", 32'(pulse_b[2]), 32'd1);
    end

    // ch0: P=5 one-shot W=3, then retrigger later.
    do_cfg(0, 5, 3, 1'b1);
    for (int r = 0; r < 2; r++) begin
      do_start(3'b001);
      for (int j = 1; j <= 12; j++) begin
        @(negedge clk);
        if (j == 5) check("os_before", 32'(pulse_b[0]), 32'd0);
        if (j == 6) check("os_rise", 32'(pulse_b[0]), 32'd1);
        if (j == 6) check("os_busy_high", 32'(busy_b[0]), 32'd1);
        if (j == 8) check("os_last", 32'(pulse_b[0]), 32'd1);
        if (j == 9) check("os_fall", 32'(pulse_b[0]), 32'd0);
        if (j == 9) check("os_busy_low", 32'(busy_b[0]), 32'd0);
      end
    end

    // ch1: P=9, rewrite P=2 mid-period, then P=4 on a terminal edge.
    do_cfg(1, 9, 1, 1'b0);
    do_start(3'b010);
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      if (j == 9)  check("dbuf_old_period", 32'(pulse_b[1]), 32'd0);
      if (j == 10) check("dbuf_first", 32'(pulse_b[1]), 32'd1);
      if (j == 12) check("dbuf_gap", 32'(pulse_b[1]), 32'd0);
      if (j == 13) check("dbuf_new_p2", 32'(pulse_b[1]), 32'd1);
      if (j == 19) check("dbuf_term_write_late", 32'(pulse_b[1]), 32'd1);
      if (j == 22) check("dbuf_no_p2_pulse", 32'(pulse_b[1]), 32'd0);
      if (j == 24) check("dbuf_p4", 32'(pulse_b[1]), 32'd1);
      cfg_we = (j == 3) || (j == 15);
      cfg_ch = 2'd1; cfg_width = 16'd1; cfg_oneshot = 1'b0;
      cfg_period = (j == 3) ? 16'd2 : 16'd4;
    end
    cfg_we = 1'b0;
    do_stop(3'b010);

    // ch0: P=7 periodic with en low for 4 edges; then start+stop together.
    do_cfg(0, 7, 1, 1'b0);
    do_start(3'b001);
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      if (j == 8)  check("en_no_early", 32'(pulse_b[0]), 32'd0);
      if (j == 11) check("en_not_yet", 32'(pulse_b[0]), 32'd0);
      if (j == 12) check("en_delayed4", 32'(pulse_b[0]), 32'd1);
      if (j == 15) check("startstop_busy", 32'(busy_b[0]), 32'd0);
      if (j == 20) check("startstop_idle", 32'(pulse_b[0]), 32'd0);
      if (j == 2) en = 1'b0;
      if (j == 6) en = 1'b1;
      start_b[0] = (j == 14);
      stop_b[0]  = (j == 14);
    end

    // Asynchronous reset in the middle of a ch2 pulse.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (pulse_b[2]) found = 1'b1;
    end
    check("wait_pulse2", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_pulse", 32'(pulse_b), 32'd0);
    check("async_busy", 32'(busy_b), 32'd0);
    check("async_pulse_a", 32'(pulse_a), 32'd0);
    #1 rst = 1'b0;

    // Write to out-of-range channel 3 must leave defaults (P=10) everywhere.
    @(negedge clk);
    do_cfg(3, 0, 5, 1'b1);
    do_start(3'b111);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 1)  check("bad_ch_no_p0", 32'(pulse_b), 32'd0);
      if (j == 10) check("bad_ch_before", 32'(pulse_b), 32'd0);
      if (j == 11) check("bad_ch_default", 32'(pulse_b), 32'h7);
      if (j == 11) check("bad_ch_busy", 32'(busy_b), 32'h7);
    end
    do_stop(3'b111);

    // ch1: P=0, W=0 -> pulse every edge, constant high.
    do_cfg(1, 0, 0, 1'b0);
    do_start(3'b010);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("p0_const", 32'(pulse_b[1]), 32'd1);
    end
    do_stop(3'b010);
    check("stop_latency", 32'({pulse_b[1], busy_b[1]}), 32'd0);
    repeat (3) @(negedge clk);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
